// File: rtl/imem_if.sv
// Instruction-memory port between the multi-cycle core (master) and the ROM/RAM wrapper (slave).
// Handshake: a word transfers on a rising edge where req and valid are both 1; addr is held while req is 1.
interface imem_if #(
  parameter int PC_W = 8
);
  logic            req;
  logic [PC_W-1:0] addr;
  logic            valid;
  logic [31:0]     data;

  modport master (output req, output addr, input valid, input data);
  modport slave  (input req, input addr, output valid, output data);
endinterface

// File: rtl/cpu_multicycle_core.sv
// Multi-cycle CPU core: FETCH/DECODE/EXEC/WB with a wait-state tolerant instruction port.
// Optional feature: define CPU_MC_BEQ_EN to enable the BEQ opcode (0x09).
module cpu_multicycle_core #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 3,
  parameter int PC_W       = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  imem_if.master            imem,
  output logic [DATA_W-1:0] alu_result,
  output logic              zero_flag,
  output logic [PC_W-1:0]   pc,
  output logic              halted,
  output logic [2:0]        dbg_state
);
  localparam int NREGS = 1 << REG_ADDR_W;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_JMP   = 8'h08;
  localparam logic [7:0] OP_HALT  = 8'h0F;
`ifdef CPU_MC_BEQ_EN
  localparam logic [7:0] OP_BEQ   = 8'h09;
`endif

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t                  state, state_nxt;
  logic [31:0]             instr;
  logic [DATA_W-1:0]       regs [NREGS];
  logic [DATA_W-1:0]       rs1, rs2;
  logic [DATA_W-1:0]       exec_res;
  logic [PC_W-1:0]         pc_nxt;
  logic                    is_write;
  logic [7:0]              op;
  logic [REG_ADDR_W-1:0]   dst_idx, src1_idx, src2_idx;
  logic [PC_W-1:0]         target;
  logic                    unused_instr;

  assign op           = instr[31:24];
  assign dst_idx      = instr[16 +: REG_ADDR_W];
  assign src1_idx     = instr[8 +: REG_ADDR_W];
  assign src2_idx     = instr[0 +: REG_ADDR_W];
  assign target       = instr[16 +: PC_W];
  assign is_write     = (op <= OP_OR);
  assign unused_instr = ^instr;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= S_FETCH;
      pc         <= '0;
      regs       <= '{default: '0};
      alu_result <= '0;
      zero_flag  <= 1'b0;
      instr      <= '0;
      rs1        <= '0;
      rs2        <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_FETCH:  if (imem.valid) instr <= imem.data;
        S_DECODE: begin
          // Sources are captured here, so dst==src sees the pre-write value.
          rs1 <= regs[src1_idx];
          rs2 <= regs[src2_idx];
        end
        S_EXEC: if (is_write) begin
          alu_result <= exec_res;
          zero_flag  <= (exec_res == '0);
        end
        S_WB: begin
          if (is_write) regs[dst_idx] <= alu_result;
          pc <= pc_nxt;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  if (imem.valid) state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC:   state_nxt = (op == OP_HALT) ? S_HALT : S_WB;
      S_WB:     state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    exec_res = '0;
    case (op)
      OP_LOADI: exec_res = DATA_W'(instr[7:0]);
      OP_MOV:   exec_res = rs2;
      OP_ADD:   exec_res = rs1 + rs2;
      OP_SUB:   exec_res = rs1 + ~rs2 + DATA_W'(1);
      OP_AND:   exec_res = rs1 & rs2;
      OP_OR:    exec_res = rs1 | rs2;
      default:  exec_res = '0;
    endcase
  end

  always_comb begin
    pc_nxt = pc + PC_W'(1);
    if (op == OP_JMP) pc_nxt = target;
`ifdef CPU_MC_BEQ_EN
    else if (op == OP_BEQ && zero_flag) pc_nxt = target;
`endif
  end

  always_comb begin
    imem.req  = (state == S_FETCH);
    imem.addr = pc;
  end

  assign halted    = (state == S_HALT);
  assign dbg_state = state;

endmodule

// File: tb/tb_cpu_multicycle_core.sv
// Bench for cpu_multicycle_core: random programs and wait states against an instruction-level model.
module tb_cpu_multicycle_core;
  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 3;
  localparam int PC_W       = 8;
  localparam int NREGS      = 1 << REG_ADDR_W;
  localparam logic [31:0] HALT_W = 32'h0F00_0000;

  // ---------------- clock / reset ----------------
  logic CLK    = 1'b0;
  logic RESET  = 1'b1;
  logic reset8 = 1'b1;
  always #5 CLK = ~CLK;
  int unsigned cyc = 0;
  always @(posedge CLK) cyc++;

  // ---------------- DUT (DATA_W=32) ----------------
  imem_if #(.PC_W(PC_W)) imem();
  logic [DATA_W-1:0] alu_result;
  logic              zero_flag;
  logic [PC_W-1:0]   pc;
  logic              halted;
  logic [2:0]        dbg_state;

  cpu_multicycle_core #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .PC_W(PC_W)) dut (
    .CLK(CLK), .RESET(RESET), .imem(imem), .alu_result(alu_result),
    .zero_flag(zero_flag), .pc(pc), .halted(halted), .dbg_state(dbg_state)
  );

  // ---------------- DUT (DATA_W=8) ----------------
  imem_if #(.PC_W(PC_W)) imem8();
  logic [7:0]      alu8;
  logic            zero8;
  logic [PC_W-1:0] pc8;
  logic            halted8;
  logic [2:0]      dbg8;

  cpu_multicycle_core #(.DATA_W(8), .REG_ADDR_W(REG_ADDR_W), .PC_W(PC_W)) dut8 (
    .CLK(CLK), .RESET(reset8), .imem(imem8), .alu_result(alu8),
    .zero_flag(zero8), .pc(pc8), .halted(halted8), .dbg_state(dbg8)
  );

  // ---------------- instruction memories ----------------
  logic [31:0] rom  [256];
  logic [31:0] rom8 [256];
  int  max_wait  = 0;
  bit  stall     = 0;
  int  wait_left = 0;
  bit  resp_hs;

  always @(posedge CLK) begin
    resp_hs = imem.req && imem.valid;
    #1;
    if (RESET || resp_hs) wait_left = int'($urandom_range(max_wait, 0));
    if (imem.req && !stall && wait_left == 0) begin
      imem.valid = 1'b1;
      imem.data  = rom[imem.addr];
    end else begin
      imem.valid = 1'b0;
      imem.data  = $urandom;
      if (imem.req && wait_left > 0) wait_left--;
    end
  end

  always @(posedge CLK) begin
    #1;
    imem8.valid = imem8.req;
    imem8.data  = rom8[imem8.addr];
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  bit abort = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (one call per instruction) ----------------
  logic [DATA_W-1:0] m_regs [NREGS];
  logic [DATA_W-1:0] m_alu;
  logic              m_zero;
  logic [PC_W-1:0]   m_pc;
  bit                m_halt;

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    m_alu = '0; m_zero = 1'b0; m_pc = '0; m_halt = 0;
  endtask

  task automatic model_exec(input logic [31:0] ins);
    logic [7:0]        op;
    logic [DATA_W-1:0] a, b, r;
    bit                wr;
    op = ins[31:24];
    a  = m_regs[ins[8 +: REG_ADDR_W]];
    b  = m_regs[ins[0 +: REG_ADDR_W]];
    wr = 1;
    r  = '0;
    case (op)
      8'h00:   r = DATA_W'(ins[7:0]);
      8'h01:   r = b;
      8'h02:   r = a + b;
      8'h03:   r = a - b;
      8'h04:   r = a & b;
      8'h05:   r = a | b;
      default: wr = 0;
    endcase
    if (wr) begin
      m_regs[ins[16 +: REG_ADDR_W]] = r;
      m_alu  = r;
      m_zero = (r == '0);
      m_pc   = m_pc + 1'b1;
    end else if (op == 8'h08) m_pc = ins[16 +: PC_W];
    else if (op == 8'h0F) m_halt = 1;
`ifdef CPU_MC_BEQ_EN
    else if (op == 8'h09 && m_zero) m_pc = ins[16 +: PC_W];
`endif
    else m_pc = m_pc + 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic fill_halt();
    for (int i = 0; i < 256; i++) rom[i] = HALT_W;
  endtask

  function automatic logic [31:0] rand_ins();
    logic [7:0] op;
    int sel;
    sel = int'($urandom_range(99, 0));
    if      (sel < 10) op = 8'h00;
    else if (sel < 20) op = 8'h01;
    else if (sel < 35) op = 8'h02;
    else if (sel < 50) op = 8'h03;
    else if (sel < 60) op = 8'h04;
    else if (sel < 70) op = 8'h05;
    else if (sel < 76) op = 8'h08;
    else if (sel < 86) op = 8'h09;
    else if (sel < 88) op = 8'h0F;
    else               op = 8'($urandom_range(255, 6));
    return {op, 8'($urandom), 8'($urandom), 8'($urandom)};
  endfunction

  // Applies one reset cycle and checks the reset state; ends at a negedge with RESET low.
  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    stall = 0;
    @(negedge CLK);
    model_reset();
    abort = 0;
    check("rst_pc", pc, 0);
    check("rst_req", imem.req, 1);
    check("rst_alu", alu_result, 0);
    check("rst_zero", zero_flag, 0);
    check("rst_halted", halted, 0);
    RESET = 1'b0;
  endtask

  // Called at a negedge while fetching; returns at the negedge after the instruction retires.
  task automatic step_instr();
    int waited;
    waited = 0;
    while (!(imem.req && imem.valid)) begin
      check("fetch_req", imem.req, 1);
      check("fetch_addr_hold", imem.addr, m_pc);
      waited++;
      if (waited > 20) begin
        check("fetch_timeout", 0, 1);
        abort = 1;
        return;
      end
      @(negedge CLK);
    end
    if (max_wait == 0) check("zero_wait", waited, 0);
    check("fetch_addr", imem.addr, m_pc);
    model_exec(rom[imem.addr]);
    repeat (3) @(negedge CLK);
    check("alu_result", alu_result, m_alu);
    check("zero_flag", zero_flag, m_zero);
    if (m_halt) begin
      check("halt_flag", halted, 1);
      check("halt_req", imem.req, 0);
      check("halt_pc", pc, m_pc);
      return;
    end
    @(negedge CLK);
    check("pc", pc, m_pc);
    check("not_halted", halted, 0);
    check("refetch_req", imem.req, 1);
  endtask

  task automatic run_instrs(input int n);
    for (int k = 0; k < n && !m_halt && !abort; k++) step_instr();
    if (m_halt) begin
      repeat (4) begin
        @(negedge CLK);
        check("halt_hold", halted, 1);
        check("halt_hold_req", imem.req, 0);
        check("halt_hold_pc", pc, m_pc);
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int unsigned t0;
    int w;
    fill_halt();
    for (int i = 0; i < 256; i++) rom8[i] = HALT_W;
    repeat (2) @(negedge CLK);

    // LOADI/LOADI/SUB at zero wait states: 4 cycles per instruction
    max_wait = 0;
    rom[0] = 32'h0001_0005;
    rom[1] = 32'h0002_0003;
    rom[2] = 32'h0303_0102;
    do_reset();
    t0 = cyc;
    run_instrs(3);
    check("sub_cycles", cyc - t0, 12);
    check("sub_alu", alu_result, 2);
    check("sub_zero", zero_flag, 0);
    run_instrs(2);

    // JMP 0x10 then HALT; reset must release the halt
    fill_halt();
    rom[0]     = 32'h0810_0000;
    rom[1]     = 32'h0001_0001;
    rom[8'h10] = HALT_W;
    do_reset();
    run_instrs(4);
    check("jmp_halt_pc", pc, 8'h10);
    check("jmp_halted", halted, 1);
    do_reset();

    // Zero-flag driven branch (or NOP when the branch opcode is not built)
    fill_halt();
    rom[0]     = 32'h0301_0101;
    rom[1]     = 32'h0920_0000;
    rom[8'h20] = 32'h0002_0007;
    rom[8'h21] = 32'h0940_0000;
    max_wait = 2;
    do_reset();
    run_instrs(6);
`ifdef CPU_MC_BEQ_EN
    check("beq_final_pc", pc, 8'h22);
`else
    check("beq_final_pc", pc, 8'h02);
`endif

    // Random programs with random wait states, each ended by a reset during a stalled fetch
    for (int p = 0; p < 10; p++) begin
      max_wait = int'($urandom_range(3, 0));
      for (int i = 0; i < 256; i++) rom[i] = rand_ins();
      do_reset();
      run_instrs(40);
      stall = 1;
      w = 0;
      while (!(imem.req && !imem.valid) && !halted && w < 12) begin
        @(negedge CLK);
        w++;
      end
      @(negedge CLK);
      do_reset();
    end

    // 8-bit datapath wraps 0xFF + 1 to zero
    rom8[0] = 32'h0001_00FF;
    rom8[1] = 32'h0002_0001;
    rom8[2] = 32'h0203_0102;
    rom8[3] = HALT_W;
    @(negedge CLK);
    reset8 = 1'b0;
    w = 0;
    while (!halted8 && w < 40) begin
      @(negedge CLK);
      w++;
    end
    check("w8_halted", halted8, 1);
    check("w8_alu", alu8, 8'h00);
    check("w8_zero", zero8, 1);
    check("w8_pc", pc8, 8'h03);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
